// File: rtl/btb_predictor_pkg.sv
// Shared core definitions for the branch target buffer: counter state encodings,
// control-flow opcodes and PC helpers.
package btb_predictor_pkg;

  typedef enum logic [1:0] {
    STRONG_NOT_TAKEN = 2'b00,
    WEAK_NOT_TAKEN   = 2'b01,
    STRONG_TAKEN     = 2'b10,
    WEAK_TAKEN       = 2'b11
  } btb_state_e;

  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [31:0] ZERO_32BIT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP    = 32'd4;

  function automatic logic [31:0] pc_next_seq(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

  // Both taken encodings share bit 1; spelled out so the intent survives re-encoding.
  function automatic logic predicts_taken(input btb_state_e s);
    return (s == STRONG_TAKEN) || (s == WEAK_TAKEN);
  endfunction

endpackage

// File: rtl/btb_predictor_if.sv
// Fetch lookup and execute resolution signals of the BTB.
// Optional counters appear only when BTB_STATS_EN is defined.
interface btb_predictor_if;

  logic [31:0] if_pc;
  logic        pred_taken_if;
  logic [31:0] pred_target_if;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        ex_actual_taken;
  logic [31:0] ex_actual_target;
  logic        modify_pc_ex;
  logic [31:0] redirect_pc_ex;
`ifdef BTB_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  modport master (
    output if_pc, ex_valid, ex_pc, ex_pred_taken, ex_pred_target,
           ex_actual_taken, ex_actual_target,
    input  pred_taken_if, pred_target_if, modify_pc_ex, redirect_pc_ex
`ifdef BTB_STATS_EN
    , input stat_branches, stat_mispredicts
`endif
  );

  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_pred_taken, ex_pred_target,
           ex_actual_taken, ex_actual_target,
    output pred_taken_if, pred_target_if, modify_pc_ex, redirect_pc_ex
`ifdef BTB_STATS_EN
    , output stat_branches, stat_mispredicts
`endif
  );

endinterface

// File: rtl/btb_sat_counter.sv
// Two-bit saturating direction counter next-state function.
// Order along the taken axis: SNT -> WNT -> WT -> ST.
module btb_sat_counter
  import btb_predictor_pkg::*;
(
  input  btb_state_e state_i,
  input  logic       taken_i,
  output btb_state_e state_o
);

  always_comb begin
    state_o = state_i;
    if (taken_i) begin
      case (state_i)
        STRONG_NOT_TAKEN: state_o = WEAK_NOT_TAKEN;
        WEAK_NOT_TAKEN:   state_o = WEAK_TAKEN;
        WEAK_TAKEN:       state_o = STRONG_TAKEN;
        STRONG_TAKEN:     state_o = STRONG_TAKEN;
        default:          state_o = state_i;
      endcase
    end else begin
      case (state_i)
        STRONG_TAKEN:     state_o = WEAK_TAKEN;
        WEAK_TAKEN:       state_o = WEAK_NOT_TAKEN;
        WEAK_NOT_TAKEN:   state_o = STRONG_NOT_TAKEN;
        STRONG_NOT_TAKEN: state_o = STRONG_NOT_TAKEN;
        default:          state_o = state_i;
      endcase
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters: combinational
// IF lookup, EX mispredict detection, table update one edge later. Stats: BTB_STATS_EN.
module btb_predictor
  import btb_predictor_pkg::*;
#(
  parameter int BTB_ENTRIES = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  btb_predictor_if.slave bus
);

  localparam int IW    = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IW;

  typedef logic [TAG_W-1:0] tag_t;

  logic [BTB_ENTRIES-1:0] valid_d, valid_q;
  tag_t                   tag_d    [BTB_ENTRIES];
  tag_t                   tag_q    [BTB_ENTRIES];
  logic [31:0]            target_d [BTB_ENTRIES];
  logic [31:0]            target_q [BTB_ENTRIES];
  btb_state_e             state_d  [BTB_ENTRIES];
  btb_state_e             state_q  [BTB_ENTRIES];

  logic [IW-1:0] if_idx, ex_idx;
  tag_t          if_tag, ex_tag;
  logic          if_hit, ex_hit;
  logic          dir_wrong, tgt_wrong;
  btb_state_e    ex_state_next;
  logic          unused_pc_bits;

  assign if_idx = bus.if_pc[IW+1:2];
  assign if_tag = bus.if_pc[31:IW+2];
  assign ex_idx = bus.ex_pc[IW+1:2];
  assign ex_tag = bus.ex_pc[31:IW+2];
  assign unused_pc_bits = ^{bus.if_pc[1:0], bus.ex_pc[1:0]};

  // Lookup reads registered contents only, so a same-index update is not bypassed.
  assign if_hit             = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign bus.pred_taken_if  = if_hit && predicts_taken(state_q[if_idx]);
  assign bus.pred_target_if = if_hit ? target_q[if_idx] : pc_next_seq(bus.if_pc);

  assign dir_wrong          = bus.ex_pred_taken != bus.ex_actual_taken;
  assign tgt_wrong          = bus.ex_pred_taken && bus.ex_actual_taken &&
                              (bus.ex_pred_target != bus.ex_actual_target);
  assign bus.modify_pc_ex   = rst_n && bus.ex_valid && (dir_wrong || tgt_wrong);
  assign bus.redirect_pc_ex = bus.ex_actual_taken ? bus.ex_actual_target
                                                  : pc_next_seq(bus.ex_pc);

  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  btb_sat_counter u_sat_counter (
    .state_i (state_q[ex_idx]),
    .taken_i (bus.ex_actual_taken),
    .state_o (ex_state_next)
  );

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    state_d  = state_q;
    if (bus.ex_valid) begin
      if (ex_hit) begin
        state_d[ex_idx] = ex_state_next;
        if (bus.ex_actual_taken) target_d[ex_idx] = bus.ex_actual_target;
      end else if (bus.ex_actual_taken) begin
        // Taken miss evicts whatever alias currently owns the slot.
        valid_d[ex_idx]  = 1'b1;
        tag_d[ex_idx]    = ex_tag;
        target_d[ex_idx] = bus.ex_actual_target;
        state_d[ex_idx]  = WEAK_TAKEN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Payload is qualified by valid, so it carries no reset.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
    state_q  <= state_d;
  end

`ifdef BTB_STATS_EN
  logic [31:0] stat_branches_d, stat_branches_q;
  logic [31:0] stat_mispredicts_d, stat_mispredicts_q;

  always_comb begin
    stat_branches_d    = stat_branches_q + {31'd0, bus.ex_valid};
    stat_mispredicts_d = stat_mispredicts_q + {31'd0, bus.modify_pc_ex};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_q    <= ZERO_32BIT;
      stat_mispredicts_q <= ZERO_32BIT;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign bus.stat_branches    = stat_branches_q;
  assign bus.stat_mispredicts = stat_mispredicts_q;
`endif

endmodule
